csr_trap_seq: RTL and testbench

- Sequencer and arbiter in front of the single-write-port CSR file.
- Shares the CSR read/write ports between pipeline CSR instructions, trap entry and mret.
- Trap entry and mret need several CSR updates, so the block runs them as a multi-cycle sequence: one CSR write per cycle, read-modify-write of mstatus, then a single-cycle PC redirect pulse to fetch.

---
 rtl/csr_trap_seq.sv | 155 +++++++++++++++
 tb/tb_csr_trap_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_seq.sv
// Arbitrates the single CSR write port among pipeline CSR writes, trap entry and mret.
// Trap and mret run as multi-cycle write sequences that end with a one-cycle fetch redirect.
module csr_trap_seq #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trap_valid,
  output logic              trap_ready,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_tval,
  input  logic              mret_valid,
  output logic              mret_ready,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CSR_AW-1:0] req_waddr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [CSR_AW-1:0] pipe_raddr,
  output logic [XLEN-1:0]   pipe_rdata,
  output logic [CSR_AW-1:0] csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_wen,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              busy,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] A_MTVAL   = CSR_AW'(12'h343);

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_REDIR, M_STAT, M_REDIR
  } state_t;

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_cause, r_pc, r_tval;
  logic [XLEN-1:0] w_stat, w_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cause <= '0;
      r_pc    <= '0;
      r_tval  <= '0;
    end else begin
      r_state <= w_next;
      if (trap_ready) begin
        r_cause <= trap_cause;
        r_pc    <= trap_pc;
        r_tval  <= trap_tval;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    trap_ready     = 1'b0;
    mret_ready     = 1'b0;
    req_ready      = 1'b0;
    busy           = (r_state != IDLE);
    csr_raddr      = pipe_raddr;
    pipe_rdata     = '0;
    csr_wen        = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    w_stat         = csr_rdata;
    w_base         = csr_rdata & ~XLEN'(3);

    case (r_state)
      IDLE: begin
        pipe_rdata = csr_rdata;
        // Accepts are gated by reset so nothing leaks out while reset is held low.
        if (reset) begin
          if (trap_valid) begin
            trap_ready = 1'b1;
            w_next     = T_EPC;
          end else if (mret_valid) begin
            mret_ready = 1'b1;
            w_next     = M_STAT;
          end else if (req_valid) begin
            req_ready = 1'b1;
            csr_wen   = 1'b1;
            csr_waddr = req_waddr;
            csr_wdata = req_wdata;
          end
        end
      end
      T_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MEPC;
        csr_wdata = r_pc;
        w_next    = T_CAUSE;
      end
      T_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MCAUSE;
        csr_wdata = r_cause;
        w_next    = T_TVAL;
      end
      T_TVAL: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MTVAL;
        csr_wdata = r_tval;
        w_next    = T_STAT;
      end
      T_STAT: begin
        csr_raddr     = A_MSTATUS;
        w_stat[7]     = csr_rdata[3];
        w_stat[3]     = 1'b0;
        w_stat[12:11] = 2'b11;
        csr_wen       = 1'b1;
        csr_waddr     = A_MSTATUS;
        csr_wdata     = w_stat;
        w_next        = T_REDIR;
      end
      T_REDIR: begin
        csr_raddr      = A_MTVEC;
        redirect_valid = 1'b1;
        // Vectored offset 4*cause[XLEN-2:0] wraps at XLEN, so only the low XLEN-2 bits survive.
        if (csr_rdata[1:0] == 2'b01 && r_cause[XLEN-1])
          redirect_pc = w_base + {r_cause[XLEN-3:0], 2'b00};
        else
          redirect_pc = w_base;
        w_next = IDLE;
      end
      M_STAT: begin
        csr_raddr     = A_MSTATUS;
        w_stat[3]     = csr_rdata[7];
        w_stat[7]     = 1'b1;
        w_stat[12:11] = 2'b00;
        csr_wen       = 1'b1;
        csr_waddr     = A_MSTATUS;
        csr_wdata     = w_stat;
        w_next        = M_REDIR;
      end
      M_REDIR: begin
        csr_raddr      = A_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed bench for csr_trap_seq with a behavioural CSR file behind the write port.
module tb_csr_trap_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        trap_valid, mret_valid, req_valid;
  logic        trap_ready, mret_ready, req_ready;
  logic [63:0] trap_cause, trap_pc, trap_tval, req_wdata;
  logic [11:0] req_waddr, pipe_raddr, csr_raddr, csr_waddr;
  logic [63:0] pipe_rdata, csr_rdata, csr_wdata, redirect_pc;
  logic        csr_wen, busy, redirect_valid;

  logic [63:0] mem [0:4095] = '{default: '0};
  assign csr_rdata = mem[csr_raddr];
  always @(posedge clk) if (csr_wen) mem[csr_waddr] <= csr_wdata;

  always #5 clk = ~clk;

  csr_trap_seq #(.XLEN(64), .CSR_AW(12)) dut (
    .clk(clk), .reset(reset),
    .trap_valid(trap_valid), .trap_ready(trap_ready),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .mret_ready(mret_ready),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .pipe_raddr(pipe_raddr), .pipe_rdata(pipe_rdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [2:0]  vld;   // {trap, mret, req}
    logic [63:0] cause, pc, tval;
    logic [11:0] wa;
    logic [63:0] wd;
    logic [11:0] pra;
    logic [3:0]  erdy;  // {trap_ready, mret_ready, req_ready, csr_wen}
    logic [11:0] ewa;
    logic [63:0] ewd;
    logic [1:0]  ebr;   // {busy, redirect_valid}
    logic [63:0] erpc, eprd;
  } vec_t;

  vec_t vt[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] vld, input logic [63:0] cause, pc, tval,
                              input logic [11:0] wa, input logic [63:0] wd, input logic [11:0] pra,
                              input logic [3:0] erdy, input logic [11:0] ewa, input logic [63:0] ewd,
                              input logic [1:0] ebr, input logic [63:0] erpc, eprd);
    vec_t v;
    v.vld = vld; v.cause = cause; v.pc = pc; v.tval = tval; v.wa = wa; v.wd = wd; v.pra = pra;
    v.erdy = erdy; v.ewa = ewa; v.ewd = ewd; v.ebr = ebr; v.erpc = erpc; v.eprd = eprd;
    return v;
  endfunction

  task automatic drive(input logic [2:0] vld, input logic [63:0] cause, pc, tval,
                       input logic [11:0] wa, input logic [63:0] wd, input logic [11:0] pra);
    {trap_valid, mret_valid, req_valid} = vld;
    trap_cause = cause; trap_pc = pc; trap_tval = tval;
    req_waddr = wa; req_wdata = wd; pipe_raddr = pra;
  endtask

  // Collision expectations per cycle: {trap_ready, mret_ready, req_ready, csr_wen, busy, redirect_valid}
  logic [5:0]  col_flags [0:9] = '{6'b100000, 6'b000110, 6'b000110, 6'b000110, 6'b000110,
                                    6'b000011, 6'b010000, 6'b000110, 6'b000011, 6'b001100};
  logic [11:0] col_wa    [0:9] = '{12'h000, 12'h341, 12'h342, 12'h343, 12'h300,
                                    12'h000, 12'h000, 12'h300, 12'h000, 12'h340};
  logic [63:0] col_wd    [0:9] = '{64'h0, 64'h200, 64'h3, 64'h300, 64'h1800,
                                    64'h0, 64'h0, 64'h80, 64'h0, 64'h5555};
  logic [63:0] col_rpc   [0:9] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                                    64'h8000_0100, 64'h0, 64'h0, 64'h200, 64'h0};

  initial begin
    reset = 1'b0;
    drive(3'b001, '0, '0, '0, 12'h340, 64'h1, 12'h340);
    @(negedge clk); #2;
    chk("rst.req_ready", req_ready, 1'b0);
    chk("rst.csr_wen", csr_wen, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.redirect_valid", redirect_valid, 1'b0);
    chk("rst.redirect_pc", redirect_pc, 64'h0);
    @(negedge clk);
    drive(3'b000, '0, '0, '0, '0, '0, 12'h340);
    reset = 1'b1;

    // Setup writes, pass-through, direct trap, mret, vectored interrupt, vectored-mode exception, mret.
    vt.push_back(mk(3'b001, 0, 0, 0, 12'h300, 64'h8, 12'h340, 4'b0011, 12'h300, 64'h8, 2'b00, 0, 0));
    vt.push_back(mk(3'b001, 0, 0, 0, 12'h305, 64'h8000_0100, 12'h340, 4'b0011, 12'h305, 64'h8000_0100, 2'b00, 0, 0));
    vt.push_back(mk(3'b001, 0, 0, 0, 12'h340, 64'hABCD, 12'h340, 4'b0011, 12'h340, 64'hABCD, 2'b00, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0000, 0, 0, 2'b00, 0, 64'hABCD));
    vt.push_back(mk(3'b100, 2, 64'h8000_0040, 64'hDEAD, 0, 0, 12'h300, 4'b1000, 0, 0, 2'b00, 0, 64'h8));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h341, 64'h8000_0040, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h342, 64'h2, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h343, 64'hDEAD, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h300, 64'h1880, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0000, 0, 0, 2'b11, 64'h8000_0100, 0));
    vt.push_back(mk(3'b001, 0, 0, 0, 12'h341, 64'h8000_0044, 12'h300, 4'b0011, 12'h341, 64'h8000_0044, 2'b00, 0, 64'h1880));
    vt.push_back(mk(3'b010, 0, 0, 0, 0, 0, 12'h341, 4'b0100, 0, 0, 2'b00, 0, 64'h8000_0044));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h300, 64'h88, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0000, 0, 0, 2'b11, 64'h8000_0044, 0));
    vt.push_back(mk(3'b001, 0, 0, 0, 12'h305, 64'h8000_0101, 12'h305, 4'b0011, 12'h305, 64'h8000_0101, 2'b00, 0, 64'h8000_0100));
    vt.push_back(mk(3'b100, 64'h8000_0000_0000_0007, 64'h8000_0050, 0, 0, 0, 12'h343, 4'b1000, 0, 0, 2'b00, 0, 64'hDEAD));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h341, 64'h8000_0050, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h342, 64'h8000_0000_0000_0007, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h343, 64'h0, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h300, 64'h1880, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0000, 0, 0, 2'b11, 64'h8000_011C, 0));
    vt.push_back(mk(3'b100, 5, 64'h8000_0060, 64'h77, 0, 0, 12'h343, 4'b1000, 0, 0, 2'b00, 0, 64'h0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h341, 64'h8000_0060, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h342, 64'h5, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h343, 64'h77, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h300, 64'h1800, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0000, 0, 0, 2'b11, 64'h8000_0100, 0));
    vt.push_back(mk(3'b010, 0, 0, 0, 0, 0, 12'h343, 4'b0100, 0, 0, 2'b00, 0, 64'h77));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0001, 12'h300, 64'h80, 2'b10, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h340, 4'b0000, 0, 0, 2'b11, 64'h8000_0060, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12'h300, 4'b0000, 0, 0, 2'b00, 0, 64'h80));

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].vld, vt[i].cause, vt[i].pc, vt[i].tval, vt[i].wa, vt[i].wd, vt[i].pra);
      #2;
      chk($sformatf("v%0d.trap_ready", i), trap_ready, vt[i].erdy[3]);
      chk($sformatf("v%0d.mret_ready", i), mret_ready, vt[i].erdy[2]);
      chk($sformatf("v%0d.req_ready", i), req_ready, vt[i].erdy[1]);
      chk($sformatf("v%0d.csr_wen", i), csr_wen, vt[i].erdy[0]);
      chk($sformatf("v%0d.csr_waddr", i), csr_waddr, vt[i].ewa);
      chk($sformatf("v%0d.csr_wdata", i), csr_wdata, vt[i].ewd);
      chk($sformatf("v%0d.busy", i), busy, vt[i].ebr[1]);
      chk($sformatf("v%0d.redirect_valid", i), redirect_valid, vt[i].ebr[0]);
      chk($sformatf("v%0d.redirect_pc", i), redirect_pc, vt[i].erpc);
      chk($sformatf("v%0d.pipe_rdata", i), pipe_rdata, vt[i].eprd);
    end

    // Collision: trap, mret and req raised together; mret and req held until accepted.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) drive(3'b111, 64'h3, 64'h200, 64'h300, 12'h340, 64'h5555, 12'h340);
      trap_valid = (c == 0);
      mret_valid = (c <= 6);
      req_valid  = 1'b1;
      #2;
      chk($sformatf("col%0d.flags", c),
          {trap_ready, mret_ready, req_ready, csr_wen, busy, redirect_valid}, col_flags[c]);
      chk($sformatf("col%0d.csr_waddr", c), csr_waddr, col_wa[c]);
      chk($sformatf("col%0d.csr_wdata", c), csr_wdata, col_wd[c]);
      chk($sformatf("col%0d.redirect_pc", c), redirect_pc, col_rpc[c]);
    end

    // Reset asserted during T_CAUSE; MEPC stays written, later CSRs untouched.
    @(negedge clk);
    drive(3'b100, 64'h9, 64'h123, 64'h456, 12'h0, 64'h0, 12'h340);
    #2 chk("rs.trap_ready", trap_ready, 1'b1);
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 0, 0, 12'h340);
    @(negedge clk); #2;
    chk("rs.tcause_waddr", csr_waddr, 12'h342);
    reset = 1'b0;
    #1;
    chk("rs.busy", busy, 1'b0);
    chk("rs.csr_wen", csr_wen, 1'b0);
    chk("rs.redirect_valid", redirect_valid, 1'b0);
    chk("rs.redirect_pc", redirect_pc, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("rs.mepc_kept", mem[12'h341], 64'h123);
    chk("rs.mcause_untouched", mem[12'h342], 64'h3);
    chk("rs.mtval_untouched", mem[12'h343], 64'h300);
    chk("rs.mstatus_untouched", mem[12'h300], 64'h80);
    chk("rs.idle_busy", busy, 1'b0);
    @(negedge clk);
    drive(3'b001, 0, 0, 0, 12'h340, 64'h77AA, 12'h340);
    #2;
    chk("rs.req_ready", req_ready, 1'b1);
    chk("rs.req_wen", csr_wen, 1'b1);
    chk("rs.req_wdata", csr_wdata, 64'h77AA);
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 0, 0, 12'h340);
    #2 chk("rs.req_landed", pipe_rdata, 64'h77AA);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
